sobel_acc_stream: RTL and testbench
===================================

// Module: sobel_acc_stream
// PURPOSE
//  Parametrised Sobel edge-detection accelerator, successor of the fixed 352x288 task-2 block.
//  Reads an 8-bit greyscale image (4 pixels/32-bit word, pixel 0 in bits [7:0]) from the shared word memory.
//  Writes |Gx|+|Gy| (saturated to 255) for every pixel to a destination image region in the same memory.
//  Uses a 3x3-word column window (3 rows x 3 words), so every source word is read exactly 3 times.
// PARAMETERS
//  IMG_W     352    image width in pixels; multiple of 4, >= 8
//  IMG_H     288    image height in rows, >= 3
//  SRC_BASE  0      word address of source pixel (0,0)
//  DST_BASE  25344  word address of destination pixel (0,0); WPR = IMG_W/4 words per row
// PORTS
//  clk     in   1   clock, rising edge
//  reset   in   1   asynchronous, active-low reset
//  addr    out  16  word address
//  dataR   in   32  read data, valid in the cycle after the read is issued
//  dataW   out  32  write data
//  en      out  1   memory request
//  we      out  1   1 = write, 0 = read; meaningful only when en = 1
//  start   in   1   level request to process one image
//  finish  out  1   high in DONE
// BEHAVIOUR
//  Reset (reset = 0, asynchronous): state IDLE; addr = 0, dataW = 0, en = 0, we = 0, finish = 0; window cleared.
//  Reset asserted mid-image aborts immediately; no further memory accesses occur.
//  FSM: IDLE -> RD_T -> RD_M -> RD_B -> WR -> (RD_T | WR | DONE).
//  IDLE:
//   - Waits for start = 1; row r = 0, column c = 0.
//  Column step (r, c), for c in 0..WPR-1:
//   - RD_T issues a read of row max(r-1, 0).
//   - RD_M issues a read of row r and captures the top word.
//   - RD_B issues a read of row min(r+1, IMG_H-1) and captures the middle word.
//   - WR captures the bottom word, shifts the window left by one word column, and writes output word (r, c-1).
//   - At c = 0, WR does not write (en = 0).
//  Final column (c = WPR):
//   - No reads are issued. FSM enters WR directly and writes word (r, WPR-1).
//   - The right neighbour column is outside the image.
//  Address rules:
//   - Read address = SRC_BASE + row*WPR + c.
//   - Write address = DST_BASE + r*WPR + c-1.
//   - Arithmetic is 16-bit and wraps modulo 2^16.
//  Ordering and timing:
//   - Rows are processed top to bottom, columns left to right.
//   - After WR of c = WPR, r increments; after r = IMG_H-1, the next state is DONE.
//   - Total active cycles: IMG_H*(4*WPR+1).
//   - Exactly one memory access per cycle in RD_*. en = 0 in IDLE and DONE.
//  Kernel:
//   - Gx = (p13 + 2*p23 + p33) - (p11 + 2*p21 + p31).
//   - Gy = (p31 + 2*p32 + p33) - (p11 + 2*p12 + p13).
//   - Compute in 11-bit signed; out = min(|Gx| + |Gy|, 255).
//  DONE:
//   - finish = 1. Return to IDLE when start = 0.
//   - If start remains 1, stay in DONE; no restart without a start low phase.
//  start changes after leaving IDLE are ignored until DONE.
// CONFIGURATION
//  SOBEL_BORDER_REPLICATE_EN defined:
//   - Out-of-image neighbours take the value of the nearest in-image pixel (edge replication).
//   - All pixels, including borders, get a kernel result.
//  SOBEL_BORDER_REPLICATE_EN undefined:
//   - Every pixel in row 0, row IMG_H-1, column 0 and column IMG_W-1 is written as 0x00.
//   - The read sequence and timing are identical in both builds.
// TESTING (IMG_W=8, IMG_H=4, SRC_BASE=0, DST_BASE=64 unless noted)
//  1. Uniform 0x80 image, start = 1 -> all 8 destination words = 0x00000000.
//     finish rises exactly 4*(4*2+1) = 36 cycles after leaving IDLE.
//  2. Vertical step: columns 0-3 = 0x00, columns 4-7 = 0xFF -> row 1 and row 2 pixels 3 and 4 = 0xFF.
//     Other interior pixels = 0x00. Border pixels = 0x00 when the macro is undefined.
//  3. Address/enable trace check:
//     - Row 0 reads in order 0, 0, 2, 1, 1, 3.
//     - First write to 64 occurs in the 8th active cycle with we = 1; en = 0 in the c = 0 WR cycle.
//  4. Reset pulled low while in RD_M of row 2 -> outputs at reset values next cycle; no memory accesses.
//     A fresh start then yields the same destination image as an uninterrupted run.
//  5. start held high through DONE -> finish stays 1 and no new reads occur.
//     start = 0 -> IDLE; start = 1 -> second full run.
//  6. Macro defined, step image from test 2 -> border pixels 3 and 4 in rows 0 and 3 = 0xFF; corners = 0x00.

Source files
------------

// File: rtl/sobel_acc_stream_if.sv
// Memory bus and start/finish handshake of the Sobel accelerator.
// The accelerator owns the master side; memory and controller sit on the slave side.
interface sobel_acc_stream_if;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic        finish;

  modport master (
    output addr, dataW, en, we, finish,
    input  dataR, start
  );

  modport slave (
    input  addr, dataW, en, we, finish,
    output dataR, start
  );
endinterface

// File: rtl/sobel_acc_stream.sv
// Streaming Sobel edge detector over an 8-bit greyscale image held in a shared
// word memory (4 pixels per word, pixel 0 in bits [7:0]). Each output word is
// produced from a 3x3-word window: two stored word columns (left, centre) plus
// the column currently being fetched (right). Vertical borders are replicated
// for free by clamping the row addresses.
// Optional build macro: SOBEL_BORDER_REPLICATE_EN
//   defined   -> out-of-image neighbours replicate the nearest pixel, every
//                pixel gets a kernel result
//   undefined -> all pixels on the image border are written as 0x00
module sobel_acc_stream #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 25344
) (
  input  logic clk,
  input  logic reset,
  sobel_acc_stream_if.master bus
);

  localparam logic [15:0] WPR       = 16'(IMG_W / 4);
  localparam logic [15:0] LAST_ROW  = 16'(IMG_H - 1);
  localparam logic [15:0] SRC_BASE16 = 16'(SRC_BASE);
  localparam logic [15:0] DST_BASE16 = 16'(DST_BASE);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_T = 3'd1;
  localparam logic [2:0] RD_M = 3'd2;
  localparam logic [2:0] RD_B = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]  state_reg;
  logic [15:0] r_reg;
  logic [15:0] c_reg;
  logic [31:0] top_reg;
  logic [31:0] mid_reg;
  // win_reg[row][0] = left word column, win_reg[row][1] = centre word column
  logic [31:0] win_reg [3][2];

  logic        last_col;
  logic        first_row;
  logic        last_row;
  logic [15:0] row_sel;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic [31:0] right_word [3];
  logic [7:0]  strip [3][6];
  logic [31:0] out_word;

  assign last_col  = (c_reg == WPR);
  assign first_row = (r_reg == 16'd0);
  assign last_row  = (r_reg == LAST_ROW);

  // Source row for the current read phase, clamped to the image.
  always_comb begin
    row_sel = r_reg;
    case (state_reg)
      RD_T:    row_sel = first_row ? r_reg : r_reg - 16'd1;
      RD_B:    row_sel = last_row  ? r_reg : r_reg + 16'd1;
      default: row_sel = r_reg;
    endcase
  end

  assign rd_addr = SRC_BASE16 + row_sel * WPR + c_reg;
  assign wr_addr = DST_BASE16 + r_reg * WPR + c_reg - 16'd1;

  // Right word column: the freshly fetched words, or nothing past the last column.
  always_comb begin
    right_word[0] = top_reg;
    right_word[1] = mid_reg;
    right_word[2] = bus.dataR;
    if (last_col) begin
      right_word[0] = 32'd0;
      right_word[1] = 32'd0;
      right_word[2] = 32'd0;
    end
  end

  // Six-pixel strip per window row: left neighbour, four centre pixels, right neighbour.
  always_comb begin
    for (int rw = 0; rw < 3; rw++) begin
      strip[rw][0] = win_reg[rw][0][31:24];
      for (int k = 0; k < 4; k++) begin
        strip[rw][k+1] = win_reg[rw][1][8*k +: 8];
      end
      strip[rw][5] = right_word[rw][7:0];
`ifdef SOBEL_BORDER_REPLICATE_EN
      if (c_reg == 16'd1) strip[rw][0] = win_reg[rw][1][7:0];
      if (last_col)       strip[rw][5] = win_reg[rw][1][31:24];
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pix
      logic [10:0]        pos_x, neg_x, pos_y, neg_y;
      logic signed [10:0] gx, gy;
      logic [10:0]        ax, ay;
      logic [11:0]        mag;
      logic               border;

      assign pos_x = {3'b0, strip[0][gi+2]} + {2'b0, strip[1][gi+2], 1'b0} + {3'b0, strip[2][gi+2]};
      assign neg_x = {3'b0, strip[0][gi]}   + {2'b0, strip[1][gi],   1'b0} + {3'b0, strip[2][gi]};
      assign pos_y = {3'b0, strip[2][gi]}   + {2'b0, strip[2][gi+1], 1'b0} + {3'b0, strip[2][gi+2]};
      assign neg_y = {3'b0, strip[0][gi]}   + {2'b0, strip[0][gi+1], 1'b0} + {3'b0, strip[0][gi+2]};
      assign gx  = $signed(pos_x) - $signed(neg_x);
      assign gy  = $signed(pos_y) - $signed(neg_y);
      assign ax  = gx[10] ? (~gx + 11'd1) : gx;
      assign ay  = gy[10] ? (~gy + 11'd1) : gy;
      assign mag = {1'b0, ax} + {1'b0, ay};

`ifdef SOBEL_BORDER_REPLICATE_EN
      assign border = 1'b0;
`else
      // Pixel 0 of word 0 is written at c = 1; pixel 3 of the last word at c = WPR.
      assign border = first_row | last_row
                    | ((gi == 0) ? (c_reg == 16'd1) : 1'b0)
                    | ((gi == 3) ? last_col : 1'b0);
`endif

      assign out_word[8*gi +: 8] = border ? 8'h00 : ((mag > 12'd255) ? 8'hFF : mag[7:0]);
    end
  endgenerate

  // Memory request decode from the current state.
  always_comb begin
    bus.addr  = 16'd0;
    bus.dataW = 32'd0;
    bus.en    = 1'b0;
    bus.we    = 1'b0;
    case (state_reg)
      RD_T, RD_M, RD_B: begin
        bus.en   = 1'b1;
        bus.addr = rd_addr;
      end
      WR: begin
        if (c_reg != 16'd0) begin
          bus.en    = 1'b1;
          bus.we    = 1'b1;
          bus.addr  = wr_addr;
          bus.dataW = out_word;
        end
      end
      default: ;
    endcase
  end

  assign bus.finish = (state_reg == DONE);

  // Sequencer: row/column walk, word capture and window shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      r_reg     <= 16'd0;
      c_reg     <= 16'd0;
      top_reg   <= 32'd0;
      mid_reg   <= 32'd0;
      for (int rw = 0; rw < 3; rw++) begin
        win_reg[rw][0] <= 32'd0;
        win_reg[rw][1] <= 32'd0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          r_reg <= 16'd0;
          c_reg <= 16'd0;
          if (bus.start) state_reg <= RD_T;
        end
        RD_T: state_reg <= RD_M;
        RD_M: begin
          top_reg   <= bus.dataR;
          state_reg <= RD_B;
        end
        RD_B: begin
          mid_reg   <= bus.dataR;
          state_reg <= WR;
        end
        WR: begin
          for (int rw = 0; rw < 3; rw++) begin
            win_reg[rw][0] <= win_reg[rw][1];
            win_reg[rw][1] <= right_word[rw];
          end
          if (last_col) begin
            c_reg <= 16'd0;
            if (last_row) begin
              state_reg <= DONE;
            end else begin
              r_reg     <= r_reg + 16'd1;
              state_reg <= RD_T;
            end
          end else begin
            c_reg     <= c_reg + 16'd1;
            state_reg <= (c_reg + 16'd1 == WPR) ? WR : RD_T;
          end
        end
        DONE: if (!bus.start) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_acc_stream.sv
// Directed bench for sobel_acc_stream on an 8x4 image (SRC_BASE 0, DST_BASE 64).
// Expected destination images are hand-computed constants; expectations for the
// SOBEL_BORDER_REPLICATE_EN build are selected with the same macro.
module tb_sobel_acc_stream;

  logic clk;
  logic reset;
  sobel_acc_stream_if bus ();

  sobel_acc_stream #(
    .IMG_W(8), .IMG_H(4), .SRC_BASE(0), .DST_BASE(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: registered read, one access per cycle, plus a bench load port.
  logic [31:0] mem [128];
  logic [31:0] rd_data;
  logic        ld_en;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  int          acc_cnt;

  initial acc_cnt = 0;
  initial rd_data = 32'd0;

  always @(posedge clk) begin
    if (bus.en) begin
      acc_cnt <= acc_cnt + 1;
      if (bus.we) mem[bus.addr[6:0]] <= bus.dataW;
      else        rd_data <= mem[bus.addr[6:0]];
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end
  assign bus.dataR = rd_data;

  int checks_cnt;
  int errors_cnt;
  logic [31:0] src_img [8];
  logic [31:0] exp_img [8];
  logic        tr_en   [8];
  logic        tr_we   [8];
  logic [15:0] tr_addr [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mem_load(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Source image into words 0..7, destination poisoned so missing writes show.
  task automatic load_src();
    for (int i = 0; i < 8; i++) mem_load(7'(i), src_img[i]);
    for (int i = 0; i < 8; i++) mem_load(7'(64 + i), 32'hDEADBEEF);
  endtask

  // Raise start, trace the first 8 cycles, wait for finish; lat = cycles from first request to finish.
  task automatic run_image(input string tag, output int lat);
    int first_en;
    first_en = 0;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n <= 8) begin
        tr_en[n-1] = bus.en; tr_we[n-1] = bus.we; tr_addr[n-1] = bus.addr;
      end
      if (first_en == 0 && bus.en) first_en = n;
      if (bus.finish) begin
        lat = n - first_en;
        break;
      end
    end
    if (lat < 0) check({tag, "_finish_timeout"}, 32'(bus.finish), 32'd1);
    $display("run %s: latency %0d", tag, lat);
  endtask

  task automatic end_run();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_dst(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_dst%0d", tag, i), mem[64+i], exp_img[i]);
  endtask

  int lat;
  int acc0;
  logic [15:0] rd_seq [6];
  int          rd_idx [6];

  initial begin
    checks_cnt = 0; errors_cnt = 0;
    reset = 1'b0; bus.start = 1'b0;
    ld_en = 1'b0; ld_addr = 7'd0; ld_data = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en",     32'(bus.en),     32'd0);
    check("rst_we",     32'(bus.we),     32'd0);
    check("rst_addr",   32'(bus.addr),   32'd0);
    check("rst_dataW",  bus.dataW,       32'd0);
    check("rst_finish", 32'(bus.finish), 32'd0);
    reset = 1'b1;

    // Uniform image: no edges, latency H*(4*WPR+1) = 36, 24 reads + 8 writes
    src_img = '{default: 32'h80808080};
    exp_img = '{default: 32'h00000000};
    load_src();
    acc0 = acc_cnt;
    run_image("uniform", lat);
    check("uniform_latency", 32'(lat), 32'd36);
    check("uniform_accesses", 32'(acc_cnt - acc0), 32'd32);
    check_dst("uniform");

    // start held high through DONE: finish stays, no accesses; then back to IDLE
    acc0 = acc_cnt;
    repeat (8) @(negedge clk);
    check("hold_finish", 32'(bus.finish), 32'd1);
    check("hold_no_access", 32'(acc_cnt - acc0), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_finish", 32'(bus.finish), 32'd0);

    // Vertical step (second full run) with address/enable trace
    src_img = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
                32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
`ifdef SOBEL_BORDER_REPLICATE_EN
    exp_img = '{32'hFF000000, 32'h000000FF, 32'hFF000000, 32'h000000FF,
                32'hFF000000, 32'h000000FF, 32'hFF000000, 32'h000000FF};
`else
    exp_img = '{32'h00000000, 32'h00000000, 32'hFF000000, 32'h000000FF,
                32'hFF000000, 32'h000000FF, 32'h00000000, 32'h00000000};
`endif
    load_src();
    run_image("vstep", lat);
    check("vstep_latency", 32'(lat), 32'd36);
    check_dst("vstep");
    rd_seq = '{16'd0, 16'd0, 16'd2, 16'd1, 16'd1, 16'd3};
    rd_idx = '{0, 1, 2, 4, 5, 6};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("trace_rd%0d_en",   i), 32'(tr_en[rd_idx[i]]),   32'd1);
      check($sformatf("trace_rd%0d_we",   i), 32'(tr_we[rd_idx[i]]),   32'd0);
      check($sformatf("trace_rd%0d_addr", i), 32'(tr_addr[rd_idx[i]]), 32'(rd_seq[i]));
    end
    check("trace_wr_c0_en", 32'(tr_en[3]),   32'd0);
    check("trace_wr1_en",   32'(tr_en[7]),   32'd1);
    check("trace_wr1_we",   32'(tr_we[7]),   32'd1);
    check("trace_wr1_addr", 32'(tr_addr[7]), 32'd64);
    end_run();

    // Horizontal step: exercises Gy
    src_img = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef SOBEL_BORDER_REPLICATE_EN
    exp_img = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
`else
    exp_img = '{32'h00000000, 32'h00000000, 32'hFFFFFF00, 32'h00FFFFFF,
                32'hFFFFFF00, 32'h00FFFFFF, 32'h00000000, 32'h00000000};
`endif
    load_src();
    run_image("hstep", lat);
    check_dst("hstep");
    end_run();

    // Single pixel 0x10 at (row 1, col 2): unsaturated sums of 0x20
    src_img = '{32'h00000000, 32'h00000000, 32'h00100000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
`ifdef SOBEL_BORDER_REPLICATE_EN
    exp_img = '{32'h20202000, 32'h00000000, 32'h20002000, 32'h00000000,
                32'h20202000, 32'h00000000, 32'h00000000, 32'h00000000};
`else
    exp_img = '{32'h00000000, 32'h00000000, 32'h20002000, 32'h00000000,
                32'h20202000, 32'h00000000, 32'h00000000, 32'h00000000};
`endif
    load_src();
    run_image("impulse", lat);
    check_dst("impulse");
    end_run();

    // Reset during RD_M of row 2, then a fresh run of the vertical step
    src_img = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
                32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
`ifdef SOBEL_BORDER_REPLICATE_EN
    exp_img = '{32'hFF000000, 32'h000000FF, 32'hFF000000, 32'h000000FF,
                32'hFF000000, 32'h000000FF, 32'hFF000000, 32'h000000FF};
`else
    exp_img = '{32'h00000000, 32'h00000000, 32'hFF000000, 32'h000000FF,
                32'hFF000000, 32'h000000FF, 32'h00000000, 32'h00000000};
`endif
    load_src();
    @(negedge clk);
    bus.start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_rdm_en",   32'(bus.en),   32'd1);
    check("abort_rdm_we",   32'(bus.we),   32'd0);
    check("abort_rdm_addr", 32'(bus.addr), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    acc0 = acc_cnt;
    @(negedge clk);
    check("abort_en",     32'(bus.en),     32'd0);
    check("abort_we",     32'(bus.we),     32'd0);
    check("abort_addr",   32'(bus.addr),   32'd0);
    check("abort_dataW",  bus.dataW,       32'd0);
    check("abort_finish", 32'(bus.finish), 32'd0);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_access", 32'(acc_cnt - acc0), 32'd0);
    reset = 1'b1;
    load_src();
    run_image("rerun", lat);
    check("rerun_latency", 32'(lat), 32'd36);
    check_dst("rerun");
    end_run();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
